uart_tx_engine: RTL and testbench

- UART transmit serializer: the consumer end of the 8-bit TX circular FIFO.
- Pops bytes from the FIFO read port, emits 8N1 frames LSB-first on `tx`, and runs frames back-to-back while the FIFO is non-empty.
- Sits between the TX FIFO and the board UART TX pin.
- Baud timing comes from a runtime divisor driven by the UART control register.

---
 rtl/uart_tx_engine_if.sv | 20 ++
 rtl/uart_tx_engine.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read-port bundle between the FIFO (slave) and the UART TX engine (master).
interface uart_tx_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops the TX FIFO and emits LSB-first 8N1 frames on tx.
// Optional parity bit (8E1/8O1) is enabled by defining UART_TX_PARITY_EN.
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIV_BITS-1:0] baud_div,
  input  logic                parity_odd,
  uart_tx_engine_if.master    fifo,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [DIV_BITS-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  launch;
  logic                  bit_end;
  logic [DIV_BITS-1:0]   eff_div;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign eff_div = (baud_div == '0) ? DIV_BITS'(1) : baud_div;
  assign bit_end = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx is registered: each bit transition loads the next line level one cycle
  // ahead, so tx_d takes shift_q[1] when the shift happens on the same edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rd_en_d = 1'b0;
    launch  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!fifo.fifo_empty) launch = 1'b1;
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = div_q;
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q ^ parity_odd;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (!fifo.fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Shared by IDLE and back-to-back STOP: capture head, pop, start bit.
    if (launch) begin
      shift_d = fifo.fifo_rd_data;
      div_d   = eff_div;
      cnt_d   = eff_div;
      idx_d   = '0;
      rd_en_d = 1'b1;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo.fifo_rd_data;
`endif
    end
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: FIFO read-port model, per-bit line checks, pop timing.
module tb_uart_tx_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned DB = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DB-1:0] baud_div;
  logic          parity_odd;
  logic          tx;
  logic          busy;

  uart_tx_engine_if #(.DATA_WIDTH(DW)) fif ();

  uart_tx_engine #(.DATA_WIDTH(DW), .DIV_BITS(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_div   (baud_div),
    .parity_odd (parity_odd),
    .fifo       (fif.master),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: head data registered, new head visible 2 clk after a pop
  logic [7:0]  mem [0:15];
  int unsigned wr_cnt;
  int unsigned rd_ptr = 0;
  logic        hold_empty;
  logic        fifo_clr;
  logic [7:0]  rd_d1;
  int unsigned cyc = 0;
  int unsigned pop_cnt = 0;
  int unsigned viol = 0;
  int unsigned pop_cyc [0:31];
  logic        rd_en_prev = 1'b0;

  assign fif.fifo_empty = hold_empty || (rd_ptr == wr_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_d1 <= mem[rd_ptr[3:0]];
    fif.fifo_rd_data <= rd_d1;
    if (fifo_clr) begin
      rd_ptr <= 0;
    end else if (fif.fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pop_cyc[pop_cnt[4:0]] <= cyc;
      pop_cnt <= pop_cnt + 1;
    end
    if (fif.fifo_rd_en && (rd_en_prev || fif.fifo_empty)) viol <= viol + 1;
    rd_en_prev <= fif.fifo_rd_en;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[3:0]] = b;
    wr_cnt++;
  endtask

  // called at a negedge; holds empty until the head data has settled
  task automatic load2(input logic [7:0] a, input logic [7:0] b, input bit two);
    hold_empty = 1'b1;
    push(a);
    if (two) push(b);
    repeat (3) @(negedge clk);
    hold_empty = 1'b0;
  endtask

  task automatic wait_start(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 200);
    if (tx !== 1'b0) check_eq("start_timeout", 32'(tx), 32'd0);
  endtask

  // entered at the negedge of the first start-bit cycle
  task automatic check_frame(input string tag, input logic [7:0] b, input int unsigned p,
                             output int unsigned busy_n);
    logic        exp_bits [0:10];
    int unsigned nb;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    if (HAS_PAR) begin
      exp_bits[9]  = (^b) ^ parity_odd;
      exp_bits[10] = 1'b1;
      nb = 11;
    end else begin
      exp_bits[9] = 1'b1;
      nb = 10;
    end
    busy_n = 0;
    for (int k = 0; k < int'(nb); k++) begin
      logic obs;
      obs = 1'b0;
      for (int c = 0; c < int'(p); c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (c == 0) obs = tx;
        else if (tx !== exp_bits[k]) obs = tx;
        if (busy === 1'b1) busy_n++;
      end
      check_eq($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'(exp_bits[k]));
    end
  endtask

  int unsigned n, bn, bn2, s1, s2, p0;
  localparam int unsigned FB = HAS_PAR ? 11 : 10;

  initial begin
    reset_n    = 1'b0;
    baud_div   = 16'd3;
    parity_odd = 1'b0;
    hold_empty = 1'b1;
    fifo_clr   = 1'b1;
    wr_cnt     = 0;
    repeat (3) @(negedge clk);
    fifo_clr = 1'b0;

    // reset held with a non-empty FIFO
    push(8'hA5);
    hold_empty = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_en", 32'(fif.fifo_rd_en), 32'd0);
    check_eq("rst_pops", pop_cnt, 0);

    // single byte 0xA5, 4-clk bits, launch on the first clk after release
    reset_n = 1'b1;
    wait_start(n);
    check_eq("rel_latency", n, 1);
    check_eq("rel_rd_en", 32'(fif.fifo_rd_en), 32'd1);
    check_frame("a5", 8'hA5, 4, bn);
    check_eq("a5_busy_len", bn, 4 * FB);
    @(negedge clk);
    check_eq("a5_idle_busy", 32'(busy), 32'd0);
    check_eq("a5_idle_tx", 32'(tx), 32'd1);
    check_eq("a5_pops", pop_cnt, 1);

    // back-to-back 0x00, 0xFF at 2-clk bits
    p0 = pop_cnt;
    baud_div = 16'd1;
    load2(8'h00, 8'hFF, 1'b1);
    wait_start(n);
    s1 = cyc;
    check_frame("b00", 8'h00, 2, bn);
    wait_start(n);
    s2 = cyc;
    check_eq("b2b_no_gap", n, 1);
    check_eq("b2b_start_dist", s2 - s1, 2 * FB);
    check_frame("bff", 8'hFF, 2, bn);
    @(negedge clk);
    check_eq("bff_idle_busy", 32'(busy), 32'd0);
    check_eq("b2b_pops", pop_cnt - p0, 2);
    check_eq("b2b_pop_dist", pop_cyc[p0+1] - pop_cyc[p0], 2 * FB);

    // baud_div 3 -> 7 during data bits: applies to the next frame only
    baud_div = 16'd3;
    load2(8'h3C, 8'h81, 1'b1);
    wait_start(n);
    fork
      check_frame("c3c", 8'h3C, 4, bn);
      begin
        repeat (12) @(negedge clk);
        baud_div = 16'd7;
      end
    join
    check_eq("c3c_busy_len", bn, 4 * FB);
    wait_start(n);
    check_eq("c81_no_gap", n, 1);
    check_frame("c81", 8'h81, 8, bn2);
    check_eq("c81_busy_len", bn2, 8 * FB);
    @(negedge clk);
    check_eq("c81_idle_busy", 32'(busy), 32'd0);

    // reset during data bit 4 of 0x5A, another byte still queued
    baud_div = 16'd3;
    load2(8'h5A, 8'hC3, 1'b1);
    wait_start(n);
    repeat (21) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    p0 = pop_cnt;
    reset_n = 1'b0;
    #1;
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rd_en", 32'(fif.fifo_rd_en), 32'd0);
    repeat (30) @(negedge clk);
    check_eq("abort_no_pop", pop_cnt, p0);
    reset_n = 1'b1;
    wait_start(n);
    check_eq("abort_rel_latency", n, 1);
    check_frame("cc3", 8'hC3, 4, bn);
    @(negedge clk);
    check_eq("cc3_pops", pop_cnt - p0, 1);

    // baud_div = 0 behaves as 1
    baud_div = 16'd0;
    load2(8'h96, 8'h00, 1'b0);
    wait_start(n);
    check_frame("d96", 8'h96, 2, bn);
    check_eq("d96_busy_len", bn, 2 * FB);
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    baud_div   = 16'd2;
    parity_odd = 1'b0;
    load2(8'h07, 8'h00, 1'b0);
    wait_start(n);
    check_frame("p07e", 8'h07, 3, bn);
    check_eq("p07e_busy_len", bn, 33);
    @(negedge clk);
    parity_odd = 1'b1;
    load2(8'h07, 8'h00, 1'b0);
    wait_start(n);
    repeat (27) @(negedge clk);
    check_eq("p07o_parity", 32'(tx), 32'd0);
    repeat (6) @(negedge clk);
`endif

    check_eq("proto_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
